btn_debounce_bank: RTL and testbench

- Input conditioning stage directly upstream of the whack-a-mole game top.
- Takes the five raw push-button pins (Up, Down, Left, Right, Center), synchronises and debounces each one, and produces clean levels plus single-cycle press/release pulses.
- Also emits an encoded "button event" the game FSM consumes to score a whack or navigate menus.
- Runs on the 100 MHz board clock.

---
 rtl/btn_debounce_bank.sv | 159 +++++++++++++++
 tb/tb_btn_debounce_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_bank
// Brief    : Five-button synchroniser/debouncer with press/release pulses
//            and a priority-encoded button event for the game FSM.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_bank #(
    parameter int STABLE_CYCLES = 150000,
    parameter int CNT_W         = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnCenter,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic       btn_valid,
    output logic [2:0] btn_code
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ARM_PRESS   = 2'd1,
        S_HELD        = 2'd2,
        S_ARM_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [4:0] w_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_press_nxt;
    logic [4:0] w_level;
    logic [4:0] w_press;
    logic [4:0] w_release;
    logic [2:0] w_code;
    logic       r_valid;
    logic [2:0] r_code;

    assign w_raw = {btnCenter, btnRight, btnLeft, btnDown, btnUp};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_press;
        logic             r_release;

        // Exposed so the event encoder can register alongside the press pulse.
        assign w_press_nxt[gi] = (r_state == S_ARM_PRESS) && r_sync2[gi] &&
                                 (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (r_sync2[gi]) begin
                            r_state <= S_ARM_PRESS;
                            r_cnt   <= c_CNT_ONE;
                        end
                    end
                    S_ARM_PRESS: begin
                        if (!r_sync2[gi]) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_HELD;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    S_HELD: begin
                        if (!r_sync2[gi]) begin
                            r_state <= S_ARM_RELEASE;
                            r_cnt   <= c_CNT_ONE;
                        end
                    end
                    S_ARM_RELEASE: begin
                        if (r_sync2[gi]) begin
                            r_state <= S_HELD;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state   <= S_IDLE;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_level[gi]   = r_level;
        assign w_press[gi]   = r_press;
        assign w_release[gi] = r_release;
    end

    // Priority Center > Up > Down > Left > Right; losers of a tie are dropped.
    always_comb begin
        w_code = 3'd0;
        if (w_press_nxt[4])      w_code = 3'd5;
        else if (w_press_nxt[0]) w_code = 3'd1;
        else if (w_press_nxt[1]) w_code = 3'd2;
        else if (w_press_nxt[2]) w_code = 3'd3;
        else if (w_press_nxt[3]) w_code = 3'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= 3'd0;
        end else begin
            r_valid <= |w_press_nxt;
            r_code  <= w_code;
        end
    end

    assign btn_level   = w_level;
    assign btn_press   = w_press;
    assign btn_release = w_release;
    assign btn_valid   = r_valid;
    assign btn_code    = r_code;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_bank
// Brief    : Self-checking bench for btn_debounce_bank using a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_bank;
    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] pins;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       btn_valid;
    logic [2:0] btn_code;

    int total = 0;
    int bad   = 0;

    // Reference model: sync pipeline plus a run-length count of samples
    // disagreeing with the accepted level.
    logic [4:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    logic       m_valid;
    logic [2:0] m_code;
    int         m_run [5];
    int         order [5] = '{4, 0, 1, 2, 3};

    logic [4:0] seen_press, seen_rel;
    logic       seen_valid;

    btn_debounce_bank #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .btnUp      (pins[0]),
        .btnDown    (pins[1]),
        .btnLeft    (pins[2]),
        .btnRight   (pins[3]),
        .btnCenter  (pins[4]),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_valid  (btn_valid),
        .btn_code   (btn_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [4:0] p, input logic r);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
            m_valid = 1'b0; m_code = 3'd0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == STABLE) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) m_press[i] = 1'b1;
                        else          m_rel[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
            m_valid = |m_press;
            m_code  = 3'd0;
            for (int k = 0; k < 5; k++)
                if (m_code == 3'd0 && m_press[order[k]]) m_code = 3'(order[k] + 1);
            m_s2 = m_s1;
            m_s1 = p;
        end
    endtask

    task automatic step(input logic [4:0] p, input logic r, input string tag);
        pins = p;
        rst  = r;
        @(posedge clk);
        model_edge(p, r);
        @(negedge clk);
        check(tag, {btn_level, btn_press, btn_release, btn_valid, btn_code},
                   {m_lvl, m_press, m_rel, m_valid, m_code});
        check({tag, "_excl"}, {27'd0, btn_press & btn_release}, 32'd0);
        seen_press = seen_press | btn_press;
        seen_rel   = seen_rel | btn_release;
        seen_valid = seen_valid | btn_valid;
    endtask

    task automatic clear_seen();
        seen_press = '0;
        seen_rel   = '0;
        seen_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] p;
        logic       r;
        pins = '0;
        rst  = 1'b1;
        clear_seen();
        @(negedge clk);

        repeat (3) step(5'b00000, 1'b1, "reset");
        check("reset_zero", {btn_level, btn_press, btn_release, btn_valid, btn_code}, 32'd0);
        clear_seen();
        repeat (50) step(5'b00000, 1'b0, "idle");
        check("idle_quiet", {seen_press, seen_rel, seen_valid}, 32'd0);

        // Up press: pulse lands on the 6th cycle after the first high sample.
        for (int c = 1; c <= 6; c++) begin
            step(5'b00001, 1'b0, "up_rise");
            if (c == 5) check("up_press_early", btn_press, 32'd0);
        end
        check("up_press_at6", {btn_press, btn_valid, btn_code}, {23'd0, 5'b00001, 1'b1, 3'd1});
        repeat (14) step(5'b00001, 1'b0, "up_hold");
        check("up_level_held", btn_level[0], 32'd1);
        for (int c = 1; c <= 6; c++) begin
            step(5'b00000, 1'b0, "up_fall");
            if (c == 5) check("up_release_early", btn_release, 32'd0);
        end
        check("up_release_at6", btn_release, 32'b00001);
        repeat (5) step(5'b00000, 1'b0, "gap");

        // Left bounces shorter than the stable window.
        clear_seen();
        for (int c = 0; c < 8; c++) step(c[1] ? 5'b00000 : 5'b00100, 1'b0, "left_bounce");
        repeat (10) step(5'b00000, 1'b0, "left_settle");
        check("left_no_event", {seen_press, seen_rel, seen_valid, btn_level[2]}, 32'd0);

        // Down and Center together: Center wins, Down never reported later.
        for (int c = 1; c <= 6; c++) step(5'b10010, 1'b0, "dc_rise");
        check("dc_press", {btn_press, btn_valid, btn_code}, {23'd0, 5'b10010, 1'b1, 3'd5});
        clear_seen();
        repeat (10) step(5'b10010, 1'b0, "dc_hold");
        check("dc_no_repeat", seen_valid, 32'd0);
        repeat (12) step(5'b00000, 1'b0, "dc_fall");

        // Right interrupted by reset just as it would be accepted.
        repeat (5) step(5'b01000, 1'b0, "right_rise");
        clear_seen();
        repeat (2) step(5'b01000, 1'b1, "right_rst");
        check("right_rst_quiet", {seen_press, seen_valid, btn_level[3]}, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            step(5'b01000, 1'b0, "right_after");
            if (c == 5) check("right_press_early", btn_press, 32'd0);
        end
        check("right_press_at6", {btn_press, btn_code}, {24'd0, 5'b01000, 3'd4});
        repeat (12) step(5'b00000, 1'b0, "right_fall");

        // Center held with a short dropout.
        repeat (10) step(5'b10000, 1'b0, "ctr_hold");
        clear_seen();
        repeat (2) step(5'b00000, 1'b0, "ctr_drop");
        repeat (10) step(5'b10000, 1'b0, "ctr_back");
        check("ctr_still_held", {seen_rel[4], btn_level[4]}, 32'b01);
        repeat (12) step(5'b00000, 1'b0, "ctr_fall");

        // Randomised activity on all pins with occasional resets.
        p = 5'b00000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) p[$urandom_range(0, 4)] = ~p[$urandom_range(0, 4) == 0 ? 0 : 0] ^ 1'b0 ? 1'b1 : 1'b0;
            if ($urandom_range(0, 5) == 0) p = p ^ 5'(1 << $urandom_range(0, 4));
            r = ($urandom_range(0, 249) == 0);
            step(p, r, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
